frequency_synth: RTL
====================

# frequency_synth

Programmable square-wave generator, the transmit-side counterpart of the frequency counter. Accepts a target frequency in Hz over a valid/ready handshake, converts it to a half-period count of `clk_fs` cycles with a serial divider, and drives `clk_fx` at that rate. Its output loops back into the frequency counter for self-test and serves as a soft clock/strobe source in the fabric.

## Interface
- `CLK_FS_HZ`, default 50_000_000: frequency of `clk_fs` in Hz, a compile-time dividend.
- `FRE_W`, default 64: width of frequency and count words.
- `clk_fs`  in  1: system/reference clock; the only clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `fre_set`  in  FRE_W: requested output frequency in Hz.
- `set_valid`  in  1: `fre_set` is valid.
- `set_ready`  out  1: block can accept a new request.
- `clk_fx`  out  1: generated square wave, registered.
- `running`  out  1: `clk_fx` is toggling (active half count ≠ 0).
- `sat`  out  1: last request exceeded CLK_FS_HZ/2 and was clamped.
- `half_cnt`  out  FRE_W: half-period currently in effect, in `clk_fs` cycles.

## Operation
- States: IDLE (ready, nothing pending), DIV (serial divide in progress), APPLY (one cycle, result latched).
- IDLE: `set_ready`=1. On `set_valid & set_ready`, capture `fre_set` and go to DIV. `set_ready`=0 in DIV and APPLY.
- DIV: restoring divide of CLK_FS_HZ by divisor 2·`fre_set`. The divisor is FRE_W+1 bits, so there is no overflow. Exactly FRE_W iterations, one quotient bit per cycle, quotient truncated.
- APPLY: result rules:
  - `fre_set`=0 gives result 0, the stop request; `sat`←0.
  - Quotient 0 (`fre_set` > CLK_FS_HZ/2) gives result 1; `sat`←1.
  - Otherwise the result is the quotient; `sat`←0.
  - Result goes to `half_next`. Return to IDLE.
- Generator: counter `cnt` runs 0..`half_cur`-1. At the terminal count, toggle `clk_fx`, clear `cnt`, and load `half_cur`←`half_next`. The current half period always completes with the old value.
- From stopped (`half_cur`=0) with a nonzero result, load `half_cur` directly in the APPLY cycle. `cnt`←0 and `clk_fx` stays 0. The first rising edge comes `half_cur` cycles later.
- A result of 0 while running forces `clk_fx`←0, `cnt`←0 and `half_cur`←0 in the APPLY cycle. The stop is immediate.
- `half_cnt` output = `half_cur`. `running` = (`half_cur` ≠ 0).
- Output period = 2·`half_cur` `clk_fs` cycles; duty 50% exactly.

## Timing
- Reset values (async, `rst_n`=0):
  - state IDLE, `set_ready`=1.
  - `clk_fx`=0, `running`=0, `sat`=0.
  - `half_cnt`=0, `cnt`=0, `half_next`=0.
- Handshake accepted on edge N. DIV spans edges N+1..N+FRE_W. APPLY result registers on edge N+FRE_W+1, where `set_ready` returns to 1. Latency is 65 cycles at FRE_W=64.
- `set_valid` while `set_ready`=0 is ignored. The requester holds it until accepted.
- Terminal count coinciding with the APPLY cycle: the toggle loads the old `half_next`. The new value applies at the following toggle. The stop-request rule overrides this.
- `half_cur`=1: `clk_fx` toggles every cycle, i.e. CLK_FS_HZ/2.
- `rst_n` assert mid-DIV or mid-period: everything returns to reset values at once. The pending request is lost.
- Deassert of `rst_n` is synchronised externally. The first accept can occur on the first edge after release.

## Structure
- Package `freq_pkg`:
  - `FRE_W` default.
  - state enum `fs_state_t` {IDLE, DIV, APPLY}.
  - function for the saturation/zero rules.
- Sub-module `freq_div_seq`: start/done serial restoring divider, parameterised on width. It is reusable by the frequency counter for Hz normalisation.
- Top holds the FSM, the `half_next`/`half_cur` registers and the toggle counter.

## Test plan
- Reset then `fre_set`=1000 → `set_ready` low 65 cycles; `half_cnt`=25000; `clk_fx` period 50000 cycles (1 ms), first rise 25000 cycles after APPLY.
- `fre_set`=1_022_494 → `half_cnt`=24 (truncated); loop into frequency counter, measured value within ±1 count of 1_041_666.
- `fre_set`=30_000_000 → `sat`=1, `half_cnt`=1, `clk_fx` toggles every cycle; then `fre_set`=25_000_000 → `sat`=0, `half_cnt`=1.
- Running at `half_cnt`=100, request 1_000_000 (→25) → current half period finishes at 100 cycles, next half period 25; no runt pulse.
- Running, request 0 → `clk_fx`=0, `running`=0 on APPLY edge; `set_valid` pulsed during DIV ignored.
- Assert `rst_n`=0 at DIV cycle 30 → all outputs reset immediately; after release, new request completes normally in 65 cycles.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared types and helpers for the programmable square-wave generator.
// The result classification is width-agnostic so the package is reusable for any FRE_W.
package freq_pkg;

  localparam int FRE_W_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    APPLY = 2'd2
  } fs_state_t;

  typedef enum logic [1:0] {
    RES_STOP = 2'd0,
    RES_SAT  = 2'd1,
    RES_QUO  = 2'd2
  } res_kind_t;

  // Zero request stops the output; a zero quotient means the request is above
  // clk/2 and is clamped to the fastest legal half period.
  function automatic res_kind_t classify(input logic fre_zero, input logic quo_zero);
    if (fre_zero)      return RES_STOP;
    else if (quo_zero) return RES_SAT;
    else               return RES_QUO;
  endfunction

endpackage

// File: rtl/freq_div_seq.sv
// Start/done serial restoring divider: W-bit dividend, (W+1)-bit divisor,
// one quotient bit per cycle, W iterations, truncated quotient.
module freq_div_seq #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W:0]   divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] iter;
  logic [W:0]    rem;
  logic [W+1:0]  trial;
  logic          fits;

  // rem < divisor always holds, so the shifted trial needs one extra bit.
  always_comb begin
    trial = {rem, quotient[W-1]};
    fits  = (trial >= {1'b0, divisor});
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter     <= '0;
      rem      <= '0;
      quotient <= '0;
    end else if (start) begin
      iter     <= CW'(W);
      rem      <= '0;
      quotient <= dividend;
    end else if (iter != '0) begin
      iter     <= iter - CW'(1);
      rem      <= fits ? (W+1)'(trial - {1'b0, divisor}) : trial[W:0];
      quotient <= {quotient[W-2:0], fits};
    end
  end

  assign busy = (iter != '0);
  // Asserted during the final iteration: quotient is valid after this edge.
  assign done = (iter == CW'(1));

endmodule

// File: rtl/frequency_synth.sv
// Programmable square-wave generator: Hz request -> half-period count via a
// serial divider, then a toggle counter driving clk_fx with exact 50% duty.
module frequency_synth
  import freq_pkg::*;
#(
  parameter longint unsigned CLK_FS_HZ = 64'd50_000_000,
  parameter int              FRE_W     = FRE_W_DEFAULT
) (
  input  logic             clk_fs,
  input  logic             rst_n,
  input  logic [FRE_W-1:0] fre_set,
  input  logic             set_valid,
  output logic             set_ready,
  output logic             clk_fx,
  output logic             running,
  output logic             sat,
  output logic [FRE_W-1:0] half_cnt
);

  localparam logic [FRE_W-1:0] ONE = FRE_W'(1);

  fs_state_t        state, next_state;
  res_kind_t        kind;
  logic [FRE_W-1:0] fre_q;
  logic [FRE_W-1:0] div_quo;
  logic             div_busy, div_done;
  logic [FRE_W-1:0] result;
  logic [FRE_W-1:0] half_next, half_cur, cnt;
  logic             accept, apply, apply_stop;

  assign set_ready  = (state == IDLE);
  assign accept     = set_valid & set_ready;
  assign apply      = (state == APPLY);
  assign apply_stop = apply & (kind == RES_STOP);

  freq_div_seq #(.W(FRE_W)) u_div (
    .clk      (clk_fs),
    .rst_n    (rst_n),
    .start    (accept),
    .dividend (FRE_W'(CLK_FS_HZ)),
    .divisor  ({fre_q, 1'b0}),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (set_valid)                next_state = DIV;
      DIV:     if (div_busy && div_done)     next_state = APPLY;
      APPLY:                                 next_state = IDLE;
      default:                               next_state = IDLE;
    endcase
  end

  always_comb begin
    kind = classify(fre_q == '0, div_quo == '0);
    case (kind)
      RES_STOP: result = '0;
      RES_SAT:  result = ONE;
      default:  result = div_quo;
    endcase
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      fre_q     <= '0;
      half_next <= '0;
      half_cur  <= '0;
      cnt       <= '0;
      clk_fx    <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (accept) fre_q <= fre_set;
      if (apply) begin
        half_next <= result;
        sat       <= (kind == RES_SAT);
      end
      // A stop request wins over everything, including a coinciding toggle.
      if (apply_stop) begin
        clk_fx   <= 1'b0;
        cnt      <= '0;
        half_cur <= '0;
      end else if (half_cur == '0) begin
        cnt <= '0;
        if (apply) half_cur <= result;
      end else if (cnt == half_cur - ONE) begin
        // The old half_next is loaded here even in the APPLY cycle.
        clk_fx   <= ~clk_fx;
        cnt      <= '0;
        half_cur <= half_next;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  assign half_cnt = half_cur;
  assign running  = (half_cur != '0);

endmodule
